// File: rtl/nested_block_checker.sv
// nested_block_checker: streaming begin/end and fork/join nesting checker.
// Bounded type stack, sticky error, tentative view of the open word.
module nested_block_checker #(
  parameter int MAX_DEPTH   = 16,
  parameter int ENABLE_FORK = 1,
  parameter int DEPTH_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               error
);

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [2:0] LEN_MAX = 3'd7;
  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE  = DEPTH_W'(1);

  // keyword slots: 0 begin, 1 end, 2 fork, 3 join
  localparam logic [39:0] KW_TXT [4] =
    '{"begin", "end  ", "fork ", "join "};
  localparam int KW_LEN [4] = '{5, 3, 4, 4};
  localparam logic [3:0] KW_EN =
    (ENABLE_FORK != 0) ? 4'b1111 : 4'b0011;

  typedef struct packed {
    logic [DEPTH_W-1:0] sp;
    logic               err;
  } eval_t;

  function automatic logic [7:0] to_lower(
    input logic [7:0] c
  );
    if (c >= 8'h41 && c <= 8'h5A)
      return c | 8'h20;
    return c;
  endfunction

  function automatic logic [7:0] kw_char(
    input int         k,
    input logic [2:0] pos
  );
    logic [39:0] w;
    int          p;
    w = KW_TXT[k];
    p = int'(pos);
    if (p > 4)
      return 8'h00;
    return w[8*(4-p) +: 8];
  endfunction

  function automatic logic [3:0] kw_done(
    input logic [3:0] flg,
    input logic [2:0] len
  );
    logic [3:0] d;
    for (int k = 0; k < 4; k++)
      d[k] = flg[k] && (int'(len) == KW_LEN[k]);
    return d;
  endfunction

  function automatic logic top_of(
    input logic [MAX_DEPTH-1:0] stk,
    input logic [DEPTH_W-1:0]   sp
  );
    logic t;
    t = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++)
      if (int'(sp) == i + 1)
        t = stk[i];
    return t;
  endfunction

  // Effect of committing a finished keyword on the stack pointer.
  function automatic eval_t eval_kw(
    input logic [DEPTH_W-1:0] sp,
    input logic               top,
    input logic [3:0]         done
  );
    eval_t r;
    logic  opener;
    logic  closer;
    logic  ctype;
    opener = done[0] | done[2];
    closer = done[1] | done[3];
    ctype  = done[3];
    r.sp   = sp;
    r.err  = 1'b0;
    if (opener) begin
      if (sp == FULL)
        r.err = 1'b1;
      else
        r.sp = sp + ONE;
    end else if (closer) begin
      if (sp == '0) begin
        r.err = 1'b1;
      end else begin
        r.err = (top != ctype);
        r.sp  = sp - ONE;
      end
    end
    return r;
  endfunction

  logic [MAX_DEPTH-1:0] stk_q, stk_d;
  logic [DEPTH_W-1:0]   sp_q, sp_d;
  logic                 err_q, err_d;
  logic [3:0]           mflg_q, mflg_d;
  logic [2:0]           len_q, len_d;

  logic                 result_q, result_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic                 error_q, error_d;

  logic [7:0]           lc;
  logic [3:0]           done_q;
  logic                 push;
  eval_t                cmt;
  eval_t                tnt;

  assign lc     = to_lower(in);
  assign done_q = kw_done(mflg_q, len_q);
  assign cmt    = eval_kw(sp_q, top_of(stk_q, sp_q), done_q);
  assign push   = (done_q[0] | done_q[2]) && (cmt.sp != sp_q);

  // Next committed state: word tracking and commit on a space.
  always_comb begin
    stk_d  = stk_q;
    sp_d   = sp_q;
    err_d  = err_q;
    mflg_d = mflg_q;
    len_d  = len_q;
    if (in_valid) begin
      if (in == SPACE) begin
        sp_d  = cmt.sp;
        err_d = err_q | cmt.err;
        for (int i = 0; i < MAX_DEPTH; i++)
          if (push && int'(sp_q) == i)
            stk_d[i] = done_q[2];
        mflg_d = '0;
        len_d  = '0;
      end else begin
        for (int k = 0; k < 4; k++)
          mflg_d[k] = KW_EN[k]
            && (len_q == '0 || mflg_q[k])
            && (int'(len_q) < KW_LEN[k])
            && (lc == kw_char(k, len_q));
        if (len_q == LEN_MAX)
          len_d = LEN_MAX;
        else
          len_d = len_q + 3'd1;
      end
    end
  end

  // Outputs as if the stream ended after this character.
  always_comb begin
    tnt = eval_kw(sp_d, top_of(stk_d, sp_d),
                  kw_done(mflg_d, len_d));
    depth_d  = tnt.sp;
    error_d  = err_d | tnt.err;
    result_d = ~error_d && (depth_d == '0);
  end

  // Committed stack and word-match state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stk_q  <= '0;
      sp_q   <= '0;
      err_q  <= 1'b0;
      mflg_q <= '0;
      len_q  <= '0;
    end else begin
      stk_q  <= stk_d;
      sp_q   <= sp_d;
      err_q  <= err_d;
      mflg_q <= mflg_d;
      len_q  <= len_d;
    end
  end

  // Registered tentative outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= 1'b1;
      depth_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      depth_q  <= depth_d;
      error_q  <= error_d;
    end
  end

  assign result = result_q;
  assign depth  = depth_q;
  assign error  = error_q;

endmodule

// File: tb/tb_nested_block_checker.sv
// tb_nested_block_checker: table-driven vectors plus
// hand sequences for fork disable, overflow and async reset.
module tb_nested_block_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_c;
  logic       in_valid;

  logic       r0, e0;
  logic [4:0] d0;
  logic       r1, e1;
  logic [4:0] d1;
  logic       r2, e2;
  logic [1:0] d2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nested_block_checker #(.MAX_DEPTH(16), .ENABLE_FORK(1)) u0 (
    .clk(clk), .reset(reset), .in(in_c), .in_valid(in_valid),
    .result(r0), .depth(d0), .error(e0));

  nested_block_checker #(.MAX_DEPTH(16), .ENABLE_FORK(0)) u1 (
    .clk(clk), .reset(reset), .in(in_c), .in_valid(in_valid),
    .result(r1), .depth(d1), .error(e1));

  nested_block_checker #(.MAX_DEPTH(2), .ENABLE_FORK(1)) u2 (
    .clk(clk), .reset(reset), .in(in_c), .in_valid(in_valid),
    .result(r2), .depth(d2), .error(e2));

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] c;
    logic       res;
    logic [4:0] dep;
    logic       err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic v,
                     input string s, input logic res,
                     input int dep, input logic err);
    for (int i = 0; i < s.len(); i++) begin
      vec_t t;
      t.rst = rst && (i == 0);
      t.v   = v;
      t.c   = s[i];
      t.res = res;
      t.dep = 5'(dep);
      t.err = err;
      vq.push_back(t);
    end
  endtask

  task automatic step(input logic [7:0] c, input logic v);
    @(negedge clk);
    in_c     = c;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++)
      step(s[i], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #2;
    chk("rst_res", r0, 1);
    chk("rst_dep", d0, 0);
    chk("rst_err", e0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b1;
    in_c     = 8'h00;
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("por_res0", r0, 1);
    chk("por_dep0", d0, 0);
    chk("por_err0", e0, 0);
    chk("por_res2", r2, 1);
    chk("por_dep2", d2, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    add(1, 1, "hi begi", 1, 0, 0);
    add(0, 1, "n a", 0, 1, 0);

    add(1, 1, "BeGi", 1, 0, 0);
    add(0, 1, "N x En", 0, 1, 0);
    add(0, 1, "D", 1, 0, 0);

    add(1, 1, "en", 1, 0, 0);
    add(0, 1, "d begi", 0, 0, 1);
    add(0, 1, "n", 0, 1, 1);

    add(1, 1, "for", 1, 0, 0);
    add(0, 1, "k begi", 0, 1, 0);
    add(0, 1, "n joi", 0, 2, 0);
    add(0, 1, "n", 0, 1, 1);

    add(1, 1, "begi", 1, 0, 0);
    add(0, 1, "n", 0, 1, 0);
    add(0, 0, "   ", 0, 1, 0);
    add(0, 1, "x", 1, 0, 0);
    add(0, 0, "dd", 1, 0, 0);

    add(1, 1, "for", 1, 0, 0);
    add(0, 1, "k joi", 0, 1, 0);
    add(0, 1, "n", 1, 0, 0);

    add(1, 1, "begi", 1, 0, 0);
    add(0, 1, "n", 0, 1, 0);
    add(0, 1, "@ ", 1, 0, 0);

    add(1, 1, "EN", 1, 0, 0);
    add(0, 1, "D", 0, 0, 1);
    add(0, 1, "X ", 1, 0, 0);

    add(1, 1, "  en", 1, 0, 0);
    add(0, 1, "d  begi", 0, 0, 1);
    add(0, 1, "n en", 0, 1, 1);
    add(0, 1, "d", 0, 0, 1);

    foreach (vq[i]) begin
      if (vq[i].rst)
        do_reset();
      step(vq[i].c, vq[i].v);
      chk($sformatf("v%0d_res", i), r0, vq[i].res);
      chk($sformatf("v%0d_dep", i), d0, vq[i].dep);
      chk($sformatf("v%0d_err", i), e0, vq[i].err);
    end

    do_reset();
    feed("fork begin join");
    chk("nofork_dep", d1, 1);
    chk("nofork_err", e1, 0);
    chk("nofork_res", r1, 0);
    chk("fork_dep", d0, 1);
    chk("fork_err", e0, 1);

    do_reset();
    feed("begin begin begi");
    chk("ovf_pre_dep", d2, 2);
    chk("ovf_pre_err", e2, 0);
    feed("n");
    chk("ovf_dep", d2, 2);
    chk("ovf_err", e2, 1);
    chk("ovf_res", r2, 0);
    feed(" end end");
    chk("ovf_sticky_dep", d2, 0);
    chk("ovf_sticky_err", e2, 1);
    chk("ovf_sticky_res", r2, 0);

    do_reset();
    feed("begin ab");
    chk("mid_dep", d2, 1);
    chk("mid_res", r2, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_res", r2, 1);
    chk("async_dep", d2, 0);
    chk("async_err", e2, 0);
    chk("async_dep0", d0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    feed("end");
    chk("post_rst_err", e2, 1);
    chk("post_rst_dep", d2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
